// File: rtl/mole_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_ctrl_if
// Purpose  : Bundles the game-round sequencer's player/generator inputs and
//            its LED/score outputs into one port.
// Ports    : start, hole_in, btn            -> driven by master (game logic)
//            mole_led, score, misses,
//            round_cnt, hit_pulse, busy,
//            game_over                      -> driven by slave (sequencer)
// Revision : 1.0  initial release
// ============================================================================
interface mole_round_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       hole_in;
    logic [4:0]       btn;
    logic [4:0]       mole_led;
    logic [CNT_W-1:0] score;
    logic [CNT_W-1:0] misses;
    logic [CNT_W-1:0] round_cnt;
    logic             hit_pulse;
    logic             busy;
    logic             game_over;

    modport master (
        output start, hole_in, btn,
        input  mole_led, score, misses, round_cnt, hit_pulse, busy, game_over
    );

    modport slave (
        input  start, hole_in, btn,
        output mole_led, score, misses, round_cnt, hit_pulse, busy, game_over
    );
endinterface
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_ctrl
// Purpose  : Whack-a-mole round sequencer. Samples the hole generator at the
//            end of each dark gap, lights one mole for a bounded window and
//            scores button presses (hit / wrong press / timeout) over a fixed
//            number of rounds, then holds the results until restarted.
// Ports    : clk       system clock
//            reset     asynchronous, active-high, clears all state
//            bus       mole_round_ctrl_if.slave (start, hole_in, btn in;
//                      mole_led, score, misses, round_cnt, hit_pulse,
//                      busy, game_over out; all outputs registered)
// Revision : 1.0  initial release
// ============================================================================
module mole_round_ctrl #(
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int ROUNDS      = 20,
    parameter int CNT_W       = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mole_round_ctrl_if.slave  bus
);

    localparam int c_max_cyc = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int c_tmr_w   = $clog2(c_max_cyc) + 1;

    localparam logic [c_tmr_w-1:0] c_show_load = c_tmr_w'(SHOW_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_gap_load  = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_rounds    = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0]   c_one       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic [4:0]         r_btn_q;
    logic [2:0]         r_cur_hole;
    logic [4:0]         r_mole_led;
    logic [CNT_W-1:0]   r_score;
    logic [CNT_W-1:0]   r_misses;
    logic [CNT_W-1:0]   r_round_cnt;
    logic               r_hit_pulse;
    logic               r_busy;
    logic               r_game_over;

    logic [4:0]         w_rise;
    logic [4:0]         w_target;
    logic [4:0]         w_new_led;
    logic               w_hole_ok;
    logic               w_hit;
    logic               w_wrong;
    logic [CNT_W-1:0]   w_round_inc;
    logic               w_last_round;

    // Only fresh press edges count; a held button never re-triggers.
    assign w_rise       = bus.btn & ~r_btn_q;
    assign w_target     = 5'd1 << (r_cur_hole - 3'd1);
    assign w_new_led    = 5'd1 << (bus.hole_in - 3'd1);
    assign w_hole_ok    = (bus.hole_in >= 3'd1) && (bus.hole_in <= 3'd5);
    assign w_hit        = |(w_rise & w_target);
    assign w_wrong      = |(w_rise & ~w_target);
    assign w_round_inc  = r_round_cnt + c_one;
    assign w_last_round = (w_round_inc == c_rounds);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_btn_q     <= '0;
            r_cur_hole  <= '0;
            r_mole_led  <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_round_cnt <= '0;
            r_hit_pulse <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_btn_q     <= bus.btn;
            r_hit_pulse <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state     <= S_GAP;
                        r_timer     <= c_gap_load;
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_round_cnt <= '0;
                        r_mole_led  <= '0;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end

                S_GAP: begin
                    r_mole_led <= '0;
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_hole_ok) begin
                        r_cur_hole <= bus.hole_in;
                        r_mole_led <= w_new_led;
                        r_timer    <= c_show_load;
                        r_state    <= S_SHOW;
                    end
                    // Invalid hole: timer stays at zero so the generator is
                    // resampled next cycle without consuming a round.
                end

                S_SHOW: begin
                    if (w_hit || (!w_wrong && r_timer == '0)) begin
                        // Round ends: either a hit (wins over a coincident
                        // timeout) or the window expired with no press.
                        if (w_hit) begin
                            r_hit_pulse <= 1'b1;
                            if (!(&r_score)) r_score <= r_score + c_one;
                        end else if (!(&r_misses)) begin
                            r_misses <= r_misses + c_one;
                        end
                        r_mole_led  <= '0;
                        r_round_cnt <= w_round_inc;
                        if (w_last_round) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                            r_timer <= c_gap_load;
                        end
                    end else begin
                        // One miss per cycle with any wrong press, regardless
                        // of how many wrong buttons rose together.
                        if (w_wrong && !(&r_misses)) r_misses <= r_misses + c_one;
                        // Hold at zero so a wrong press on the last cycle
                        // defers the timeout by one cycle instead of wrapping.
                        if (r_timer != '0) r_timer <= r_timer - 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mole_led  = r_mole_led;
    assign bus.score     = r_score;
    assign bus.misses    = r_misses;
    assign bus.round_cnt = r_round_cnt;
    assign bus.hit_pulse = r_hit_pulse;
    assign bus.busy      = r_busy;
    assign bus.game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_round_ctrl
// Purpose  : Directed self-checking bench for mole_round_ctrl with a short
//            game (SHOW_CYCLES=8, GAP_CYCLES=4, ROUNDS=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_mole_round_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mole_round_ctrl_if #(.CNT_W(8)) bus ();

    mole_round_ctrl #(
        .SHOW_CYCLES (8),
        .GAP_CYCLES  (4),
        .ROUNDS      (3),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int sc, input int ms, input int rc);
        check({tag, ".score"},  32'(bus.score),     32'(sc));
        check({tag, ".misses"}, 32'(bus.misses),    32'(ms));
        check({tag, ".rounds"}, 32'(bus.round_cnt), 32'(rc));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.hole_in = 3'd0;
        bus.btn     = 5'd0;

        // ---------------- reset state ----------------
        tick(2);
        check("rst.led", 32'(bus.mole_led), 32'h0);
        check_cnt("rst", 0, 0, 0);
        check("rst.busy", 32'(bus.busy), 32'h0);
        check("rst.over", 32'(bus.game_over), 32'h0);
        check("rst.hit",  32'(bus.hit_pulse), 32'h0);
        reset = 1'b0;
        tick(2);
        check("idle.busy", 32'(bus.busy), 32'h0);

        // ---------------- game 1, round 1: hit ----------------
        bus.start   = 1'b1;
        bus.hole_in = 3'd3;
        tick(1);
        bus.start = 1'b0;
        check("g1.busy", 32'(bus.busy), 32'h1);
        check("g1.gapled", 32'(bus.mole_led), 32'h0);
        tick(3);
        check("g1.gapdark", 32'(bus.mole_led), 32'h0);
        tick(1);
        check("g1.show", 32'(bus.mole_led), 32'h04);
        check_cnt("g1.show", 0, 0, 0);
        tick(1);
        bus.btn = 5'b00100;
        tick(1);
        check("r1.hit", 32'(bus.hit_pulse), 32'h1);
        check("r1.led", 32'(bus.mole_led), 32'h0);
        check_cnt("r1", 1, 0, 1);
        tick(1);
        check("r1.pulse1", 32'(bus.hit_pulse), 32'h0);
        check("r1.busy", 32'(bus.busy), 32'h1);

        // ---------------- round 2: held button, start ignored, timeout ----
        tick(3);
        check("r2.show", 32'(bus.mole_led), 32'h04);
        tick(2);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(4);
        check("r2.lit", 32'(bus.mole_led), 32'h04);
        check_cnt("r2.pre", 1, 0, 1);
        tick(1);
        check("r2.timeout.led", 32'(bus.mole_led), 32'h0);
        check("r2.timeout.hit", 32'(bus.hit_pulse), 32'h0);
        check_cnt("r2", 1, 1, 2);

        // ---------------- round 3: invalid holes, then 5 ----------------
        bus.btn     = 5'd0;
        bus.hole_in = 3'd0;
        tick(4);
        check("r3.h0", 32'(bus.mole_led), 32'h0);
        bus.hole_in = 3'd7;
        tick(1);
        check("r3.h7", 32'(bus.mole_led), 32'h0);
        check("r3.h7.rounds", 32'(bus.round_cnt), 32'd2);
        bus.hole_in = 3'd5;
        tick(1);
        check("r3.h5", 32'(bus.mole_led), 32'h10);
        check("r3.h5.rounds", 32'(bus.round_cnt), 32'd2);
        bus.btn = 5'b10000;
        tick(1);
        check("r3.hit", 32'(bus.hit_pulse), 32'h1);
        check("done.over", 32'(bus.game_over), 32'h1);
        check("done.busy", 32'(bus.busy), 32'h0);
        check_cnt("done", 2, 1, 3);

        // ---------------- DONE holds, presses ignored ----------------
        for (int i = 0; i < 20; i++) begin
            bus.btn = i[0] ? 5'b11111 : 5'b00000;
            tick(1);
        end
        bus.btn = 5'd0;
        check("hold.over", 32'(bus.game_over), 32'h1);
        check("hold.led", 32'(bus.mole_led), 32'h0);
        check_cnt("hold", 2, 1, 3);

        // ---------------- game 2: restart from DONE ----------------
        bus.start   = 1'b1;
        bus.hole_in = 3'd2;
        tick(1);
        bus.start = 1'b0;
        check("g2.over", 32'(bus.game_over), 32'h0);
        check("g2.busy", 32'(bus.busy), 32'h1);
        check_cnt("g2.clr", 0, 0, 0);
        tick(4);
        check("g2.show", 32'(bus.mole_led), 32'h02);
        bus.btn = 5'b10000;
        tick(1);
        check("g2.wrong.led", 32'(bus.mole_led), 32'h02);
        check_cnt("g2.wrong", 0, 1, 0);
        bus.btn = 5'd0;
        tick(1);
        bus.btn = 5'b00011;
        tick(1);
        check("g2.multi.hit", 32'(bus.hit_pulse), 32'h1);
        check("g2.multi.led", 32'(bus.mole_led), 32'h0);
        check_cnt("g2.multi", 1, 1, 1);

        // ---------------- hit on the last SHOW cycle ----------------
        bus.btn = 5'd0;
        tick(4);
        check("g2r2.show", 32'(bus.mole_led), 32'h02);
        tick(7);
        check("g2r2.lastcyc", 32'(bus.mole_led), 32'h02);
        bus.btn = 5'b00010;
        tick(1);
        check("g2r2.edgehit", 32'(bus.hit_pulse), 32'h1);
        check_cnt("g2r2", 2, 1, 2);

        // ---------------- async reset mid-SHOW ----------------
        bus.btn = 5'd0;
        tick(4);
        check("g2r3.show", 32'(bus.mole_led), 32'h02);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("arst.led", 32'(bus.mole_led), 32'h0);
        check("arst.busy", 32'(bus.busy), 32'h0);
        check("arst.over", 32'(bus.game_over), 32'h0);
        check_cnt("arst", 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(6);
        check("post.led", 32'(bus.mole_led), 32'h0);
        check("post.busy", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game-round sequencer for the whack-a-mole design; sits directly downstream of the pseudorandom hole generator.
- Samples the generator's hole number (1..5) at the start of each round, lights the matching mole LED for a bounded window and scores the player's button press.
- Accumulates score, miss count and round count for a fixed number of rounds, then holds results until the next start.

Parameters:
- SHOW_CYCLES, 25_000_000, clock cycles a mole stays lit (timeout window).
- GAP_CYCLES, 12_500_000, clock cycles all LEDs are dark between rounds.
- ROUNDS, 20, rounds per game (1..255).
- CNT_W, 8, width of score, misses and round_cnt.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  synchronous start request, level; acted on in IDLE or DONE only
- hole_in  in  3  hole number from generator; valid values 1..5
- btn  in  5  debounced player buttons, active-high, btn[i] = hole i+1
- mole_led  out  5  one-hot lit mole, bit (hole-1); 0 when no mole
- score  out  CNT_W  hits this game
- misses  out  CNT_W  timeouts plus wrong presses this game
- round_cnt  out  CNT_W  completed rounds this game
- hit_pulse  out  1  one-cycle strobe on a scored hit
- busy  out  1  high in GAP or SHOW
- game_over  out  1  high in DONE

Behaviour:
- Reset (async, any state): state=IDLE; mole_led=0, score=0, misses=0, round_cnt=0, hit_pulse=0, busy=0, game_over=0, btn_q=0, timer=0.
- Edge detect: btn_q <= btn every cycle in every state; rise = btn & ~btn_q. Only rises act; held buttons never re-trigger.
- States: IDLE, GAP, SHOW, DONE. All outputs registered.
- IDLE: start=1 -> GAP; clear score, misses and round_cnt; timer = GAP_CYCLES-1.
- GAP:
  - mole_led=0; timer decrements each cycle.
  - At timer==0, sample hole_in. If 1..5: latch cur_hole, mole_led <= 1<<(hole_in-1), timer = SHOW_CYCLES-1, go to SHOW.
  - If hole_in is 0, 6 or 7: stay in GAP with timer=0 and resample next cycle. No round is consumed.
- SHOW, evaluated each cycle in priority order:
  - (1) rise[cur_hole-1]: hit. score+1 (saturating at all-ones), hit_pulse=1 for exactly the next cycle, mole_led <= 0, round_cnt+1. Other rises in the same cycle are ignored.
  - (2) else any rise on another bit: misses+1 per cycle with a wrong rise (not per bit). Mole stays lit; timer continues.
  - (3) else timer==0: timeout. misses+1, mole_led <= 0, round_cnt+1.
  - A hit on the timer==0 cycle counts as a hit, not a timeout.
  - Presses in GAP, IDLE or DONE are ignored and never count.
- After a hit or timeout: if the new round_cnt==ROUNDS, go to DONE; else go to GAP with timer=GAP_CYCLES-1.
- Latency: press sampled at edge k as a rise -> score, mole_led, round_cnt and hit_pulse update at edge k+1.
- DONE: game_over=1, busy=0, counters hold. start=1 -> same action as from IDLE (counters cleared, GAP entered, game_over drops).
- start is ignored while busy.
- misses saturates at all-ones.
- round_cnt never exceeds ROUNDS.

Test Plan (SHOW_CYCLES=8, GAP_CYCLES=4, ROUNDS=3):
- Reset, then start pulse with hole_in=3 held -> after 4 GAP cycles mole_led=5'b00100, busy=1; all counters 0.
- In SHOW, btn[2] rises on the 2nd SHOW cycle -> next cycle score=1, hit_pulse high 1 cycle, mole_led=0, round_cnt=1, state GAP.
- No press for 8 SHOW cycles -> misses=1, round_cnt increments, mole_led=0; holding btn from GAP into SHOW produces no hit.
- hole_in=2, rises on btn[0] and btn[1] in the same cycle -> score+1, misses unchanged. Separately, btn[4] rise alone -> misses+1 and mole stays lit.
- hole_in=0 then 7 then 5 at GAP end -> stays dark until 5 is sampled; mole_led=5'b10000; round_cnt unaffected by the invalid samples.
- Three rounds complete -> game_over=1, counters hold across 20 idle cycles. Assert reset mid-SHOW in a new game -> all outputs 0 immediately, state IDLE.
